// File: rtl/commit_trace_buffer_if.sv
// Retire-side and trace-side handshake bundle for commit_trace_buffer.
// master = writeback stage plus trace consumer; slave = the buffer itself.
interface commit_trace_buffer_if;
  logic        retire_valid;
  logic [15:0] retire_pc;
  logic        retire_regwrite;
  logic [2:0]  retire_wreg;
  logic [15:0] retire_wdata;
  logic        retire_memread;
  logic        retire_memwrite;
  logic [15:0] retire_addr;
  logic [15:0] retire_mdata;
  logic        retire_halt;
  logic        retire_stall;
  logic        trace_valid;
  logic        trace_ready;
  logic [70:0] trace_rec;

  modport master (
    output retire_valid, retire_pc, retire_regwrite, retire_wreg, retire_wdata,
           retire_memread, retire_memwrite, retire_addr, retire_mdata, retire_halt,
           trace_ready,
    input  retire_stall, trace_valid, trace_rec
  );

  modport slave (
    input  retire_valid, retire_pc, retire_regwrite, retire_wreg, retire_wdata,
           retire_memread, retire_memwrite, retire_addr, retire_mdata, retire_halt,
           trace_ready,
    output retire_stall, trace_valid, trace_rec
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO: a record appears on trace_rec the cycle after push; retire_stall only when full.
// trace_rec holds while unready. Define COMMIT_TRACE_CYCLE_CNT_EN to build the cycle_count counter.
module commit_trace_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  commit_trace_buffer_if.slave bus,
  output logic [31:0]          inst_count,
  output logic [31:0]          cycle_count,
  output logic                 done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [15:0] pc;
    logic        regwrite;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic        memread;
    logic        memwrite;
    logic [15:0] addr;
    logic [15:0] mdata;
    logic        halt;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          wr_rec;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] occ;
  logic          halted;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Stall and valid decode from occupancy alone, so the consumer's ready never reaches writeback.
  assign full  = (occ == CW'(DEPTH));
  assign empty = (occ == '0);
  assign push  = bus.retire_valid && !full && !halted;
  assign pop   = !empty && bus.trace_ready;

  assign wr_rec = '{
    pc:       bus.retire_pc,
    regwrite: bus.retire_regwrite,
    wreg:     bus.retire_wreg,
    wdata:    bus.retire_wdata,
    memread:  bus.retire_memread,
    memwrite: bus.retire_memwrite,
    addr:     bus.retire_addr,
    mdata:    bus.retire_mdata,
    halt:     bus.retire_halt
  };

  assign bus.retire_stall = full;
  assign bus.trace_valid  = !empty;
  assign bus.trace_rec    = mem[rd_ptr];
  assign done             = halted && empty;

  // Storage needs no reset: contents are only observed while trace_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_rec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      halted     <= 1'b0;
      inst_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (push && (inst_count != '1)) begin
        inst_count <= inst_count + 32'd1;
      end
      if (push && bus.retire_halt) begin
        halted <= 1'b1;
      end
    end
  end

`ifdef COMMIT_TRACE_CYCLE_CNT_EN
  // Counts the edge that accepts HALT, then freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (!halted && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed scoreboard bench for commit_trace_buffer: ordering, backpressure, wrap, halt/done, async reset.
module tb_commit_trace_buffer;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_count;
  logic [31:0] cycle_count;
  logic        done;

  commit_trace_buffer_if bus();

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .inst_count  (inst_count),
    .cycle_count (cycle_count),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          m_occ;
  logic        m_halted;
  logic [31:0] m_inst;
  logic [31:0] m_cyc;
  logic [70:0] cur_rec;
  logic [70:0] exp_q [$];

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record fields are derived from pc so every record is distinct and recomputable here.
  task automatic drive(input logic v, input logic [15:0] pc, input logic h);
    bus.retire_valid    = v;
    bus.retire_pc       = pc;
    bus.retire_regwrite = pc[1];
    bus.retire_wreg     = pc[3:1];
    bus.retire_wdata    = pc ^ 16'hA5A5;
    bus.retire_memread  = pc[2];
    bus.retire_memwrite = ~pc[2];
    bus.retire_addr     = pc + 16'h1000;
    bus.retire_mdata    = ~pc;
    bus.retire_halt     = h;
    cur_rec = {pc, pc[1], pc[3:1], pc ^ 16'hA5A5, pc[2], ~pc[2], pc + 16'h1000, ~pc, h};
  endtask

  // Called just after a falling edge: check outputs, update scoreboard, cross one rising edge.
  task automatic cycle(output logic pushed);
    logic popped;
    chk("retire_stall", bus.retire_stall, m_occ == DEPTH);
    chk("trace_valid", bus.trace_valid, m_occ > 0);
    chk("done", done, m_halted && (m_occ == 0));
    chk("inst_count", inst_count, m_inst);
`ifdef COMMIT_TRACE_CYCLE_CNT_EN
    chk("cycle_count", cycle_count, m_cyc);
`else
    chk("cycle_count", cycle_count, 71'd0);
`endif
    if (m_occ > 0) chk("trace_rec", bus.trace_rec, exp_q[0]);
    pushed = bus.retire_valid && (m_occ < DEPTH) && !m_halted;
    popped = bus.trace_ready && (m_occ > 0);
    if (popped) void'(exp_q.pop_front());
    if (pushed) exp_q.push_back(cur_rec);
    @(posedge clk);
    m_occ = m_occ + int'(pushed) - int'(popped);
    if (!m_halted) m_cyc++;
    if (pushed) begin
      m_inst++;
      if (bus.retire_halt) m_halted = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic tick();
    logic p;
    cycle(p);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 2 && m_occ > 0; i++) tick();
    chk("drain_valid", bus.trace_valid, 71'd0);
  endtask

  initial begin
    logic acc;
    checks   = 0;
    errors   = 0;
    m_occ    = 0;
    m_halted = 1'b0;
    m_inst   = '0;
    m_cyc    = '0;
    rst_n    = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    bus.trace_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", bus.retire_stall, 71'd0);
    chk("rst_valid", bus.trace_valid, 71'd0);
    chk("rst_done", done, 71'd0);
    chk("rst_inst", inst_count, 71'd0);
    chk("rst_cycle", cycle_count, 71'd0);
    rst_n = 1'b1;

    // Three back-to-back records with the consumer always ready.
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(2 * i), 1'b0);
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0);
    repeat (3) tick();
    chk("t1_inst", inst_count, 71'd3);

    // Fill while blocked, hold a fifth record against the stall.
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0100 + 16'(2 * i), 1'b0);
      tick();
    end
    drive(1'b1, 16'h0108, 1'b0);
    repeat (3) tick();
    chk("t2_stall", bus.retire_stall, 71'd1);
    chk("t2_inst", inst_count, 71'd7);
    bus.trace_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++) cycle(acc);
    chk("t2_accept", acc, 71'd1);
    drive(1'b0, 16'h0000, 1'b0);
    drain();
    chk("t2_inst_after", inst_count, 71'd8);

    // Occupancy 2, then six cycles of simultaneous push and pop across the wrap.
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h0200 + 16'(2 * i), 1'b0);
      tick();
    end
    bus.trace_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      drive(1'b1, 16'h0200 + 16'(2 * i), 1'b0);
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0);
    drain();
    chk("t3_inst", inst_count, 71'd16);

    // Asynchronous reset with three records queued and the consumer stalled.
    bus.trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0300 + 16'(2 * i), 1'b0);
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0);
    chk("t5_pre_valid", bus.trace_valid, 71'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", bus.trace_valid, 71'd0);
    chk("t5_inst", inst_count, 71'd0);
    chk("t5_done", done, 71'd0);
    chk("t5_stall", bus.retire_stall, 71'd0);
    chk("t5_cycle", cycle_count, 71'd0);
    exp_q.delete();
    m_occ    = 0;
    m_halted = 1'b0;
    m_inst   = '0;
    m_cyc    = '0;
    @(negedge clk);
    chk("t5_hold_valid", bus.trace_valid, 71'd0);
    rst_n = 1'b1;

    // One record queued, HALT accepted on the 20th edge after reset, retire_valid kept high.
    while (m_cyc < 18) tick();
    drive(1'b1, 16'h000E, 1'b0);
    tick();
    drive(1'b1, 16'h0010, 1'b1);
    tick();
    drive(1'b1, 16'h0012, 1'b0);
    repeat (3) tick();
    chk("t4_inst", inst_count, 71'd2);
    chk("t4_done_pending", done, 71'd0);
    bus.trace_ready = 1'b1;
    tick();
    chk("t4_done_one_left", done, 71'd0);
    tick();
    chk("t4_done", done, 71'd1);
    repeat (3) tick();
    chk("t4_inst_final", inst_count, 71'd2);
`ifdef COMMIT_TRACE_CYCLE_CNT_EN
    chk("t4_cycle_frozen", cycle_count, 71'd20);
`else
    chk("t4_cycle_zero", cycle_count, 71'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
